// File: rtl/global_history_index_gen.sv
// rtl/global_history_index_gen.sv - gshare GHR, checkpoint FIFO and PHT read index generator
module global_history_index_gen #(
    parameter int GHR_W      = 8,
    parameter int PHT_ADDR_W = 8,
    parameter int CKPT_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  stall,
    input  logic                  pc_valid_i,
    input  logic [31:0]           pc_i,
    input  logic                  pred_valid_i,
    input  logic                  pred_dir_i,
    input  logic                  resolve_valid_i,
    input  logic                  resolve_dir_i,
    input  logic                  resolve_mispred_i,
    output logic [PHT_ADDR_W-1:0] pht_addr_o,
    output logic [GHR_W-1:0]      ghr_o,
    output logic [GHR_W-1:0]      ghr_commit_o,
    output logic                  ckpt_full_o,
    output logic                  ckpt_empty_o,
    output logic                  ovf_o
);

    localparam int PTR_W = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;
    localparam int CNT_W = $clog2(CKPT_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CKPT_DEPTH);

    logic [GHR_W-1:0]      ckpt_mem [CKPT_DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic [PHT_ADDR_W-1:0] ghr_ext;
    logic [GHR_W-1:0]      ckpt_rd;
    logic                  push_req;
    logic                  pop;
    logic                  push_ok;
    logic                  mispred;

    // Decode this cycle's speculation/resolution events and the history zero-extension
    always_comb begin
        ghr_ext              = '0;
        ghr_ext[GHR_W-1:0]   = ghr_o;
        ckpt_rd              = ckpt_mem[rptr];
        push_req             = pred_valid_i & ~stall;
        pop                  = resolve_valid_i & (count != '0);
        mispred              = pop & resolve_mispred_i;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept
        push_ok              = push_req & ((count != DEPTH_C) | pop) & ~mispred;
        count_nxt            = count;
        if (mispred) begin
            count_nxt = '0;
        end else if (push_ok && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    // Index register: PC bits above the word offset hashed with speculative history
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pht_addr_o <= '0;
        end else if (pc_valid_i && !stall) begin
            pht_addr_o <= pc_i[PHT_ADDR_W+1:2] ^ ghr_ext;
        end
    end

    // Speculative history, checkpoint pointers/count, occupancy flags and overflow
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ghr_o        <= '0;
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            ckpt_full_o  <= 1'b0;
            ckpt_empty_o <= 1'b1;
            ovf_o        <= 1'b0;
        end else begin
            count        <= count_nxt;
            ckpt_full_o  <= (count_nxt == DEPTH_C);
            ckpt_empty_o <= (count_nxt == '0);
            if (push_req && !pop && count == DEPTH_C) begin
                ovf_o <= 1'b1;
            end
            if (mispred) begin
                // Restore history to the branch's checkpoint plus its real outcome
                ghr_o <= {ckpt_rd[GHR_W-2:0], resolve_dir_i};
                wptr  <= '0;
                rptr  <= '0;
            end else begin
                if (push_ok) begin
                    ghr_o <= {ghr_o[GHR_W-2:0], pred_dir_i};
                    wptr  <= PTR_W'((wptr + 1'b1) % CKPT_DEPTH);
                end
                if (pop) begin
                    rptr <= PTR_W'((rptr + 1'b1) % CKPT_DEPTH);
                end
            end
        end
    end

    // Checkpoint storage; contents are meaningless once count says so, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            ckpt_mem[wptr] <= ghr_o;
        end
    end

    // Architectural history advances on every resolved branch, stall or not
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ghr_commit_o <= '0;
        end else if (pop) begin
            ghr_commit_o <= {ghr_commit_o[GHR_W-2:0], resolve_dir_i};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pc_i[31:PHT_ADDR_W+2], pc_i[1:0], ckpt_rd[GHR_W-1]};

endmodule

// File: tb/tb_global_history_index_gen.sv
// tb/tb_global_history_index_gen.sv - randomized bench with queue-based gshare model
module tb_global_history_index_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall;
    logic        pc_valid_i;
    logic [31:0] pc_i;
    logic        pred_valid_i;
    logic        pred_dir_i;
    logic        resolve_valid_i;
    logic        resolve_dir_i;
    logic        resolve_mispred_i;
    logic [7:0]  pht_addr_o;
    logic [7:0]  ghr_o;
    logic [7:0]  ghr_commit_o;
    logic        ckpt_full_o;
    logic        ckpt_empty_o;
    logic        ovf_o;

    int checks = 0;
    int errors = 0;

    bit [7:0] m_ghr;
    bit [7:0] m_commit;
    bit [7:0] m_addr;
    bit       m_ovf;
    bit [7:0] m_q[$];

    global_history_index_gen #(.GHR_W(8), .PHT_ADDR_W(8), .CKPT_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .stall(stall),
        .pc_valid_i(pc_valid_i), .pc_i(pc_i),
        .pred_valid_i(pred_valid_i), .pred_dir_i(pred_dir_i),
        .resolve_valid_i(resolve_valid_i), .resolve_dir_i(resolve_dir_i),
        .resolve_mispred_i(resolve_mispred_i),
        .pht_addr_o(pht_addr_o), .ghr_o(ghr_o), .ghr_commit_o(ghr_commit_o),
        .ckpt_full_o(ckpt_full_o), .ckpt_empty_o(ckpt_empty_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst);
        bit [7:0] old_ghr;
        bit [7:0] popped;
        bit       did_pop;
        if (rst) begin
            m_ghr = 0; m_commit = 0; m_addr = 0; m_ovf = 0; m_q.delete();
            return;
        end
        old_ghr = m_ghr;
        if (pc_valid_i && !stall) m_addr = pc_i[9:2] ^ old_ghr;
        did_pop = resolve_valid_i && m_q.size() > 0;
        if (did_pop) begin
            popped = m_q.pop_front();
            m_commit = {m_commit[6:0], resolve_dir_i};
        end
        if (did_pop && resolve_mispred_i) begin
            m_ghr = {popped[6:0], resolve_dir_i};
            m_q.delete();
        end else if (pred_valid_i && !stall) begin
            if (m_q.size() < 4) begin
                m_q.push_back(old_ghr);
                m_ghr = {old_ghr[6:0], pred_dir_i};
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_addr"},   pht_addr_o,   m_addr);
        check({tag, "_ghr"},    ghr_o,        m_ghr);
        check({tag, "_commit"}, ghr_commit_o, m_commit);
        check({tag, "_full"},   ckpt_full_o,  m_q.size() == 4);
        check({tag, "_empty"},  ckpt_empty_o, m_q.size() == 0);
        check({tag, "_ovf"},    ovf_o,        m_ovf);
    endtask

    task automatic cyc(input bit rst, input bit st, input bit pv, input logic [31:0] pc,
                       input bit prv, input bit pd, input bit rv, input bit rd, input bit rm,
                       input string tag);
        resetn = !rst; stall = st; pc_valid_i = pv; pc_i = pc;
        pred_valid_i = prv; pred_dir_i = pd;
        resolve_valid_i = rv; resolve_dir_i = rd; resolve_mispred_i = rm;
        model_step(rst);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        #1;
        // 1: reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        check("t1_addr", pht_addr_o, 8'h00);
        check("t1_empty", ckpt_empty_o, 1'b1);

        // 2: index and single push
        cyc(0, 0, 1, 32'h104, 1, 1, 0, 0, 0, "t2a");
        check("t2_addr41", pht_addr_o, 8'h41);
        check("t2_ghr01", ghr_o, 8'h01);
        cyc(0, 0, 1, 32'h104, 0, 0, 0, 0, 0, "t2b");
        check("t2_addr40", pht_addr_o, 8'h40);

        // 3: fill, overflow, push + pop while full
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, "t3r");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, "t3f");
        check("t3_ghr0f", ghr_o, 8'h0F);
        check("t3_full", ckpt_full_o, 1'b1);
        cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, "t3o");
        check("t3_ghr_hold", ghr_o, 8'h0F);
        check("t3_ovf", ovf_o, 1'b1);
        cyc(0, 0, 0, 0, 1, 1, 1, 1, 0, "t3pp");
        check("t3_ghr1f", ghr_o, 8'h1F);
        check("t3_full_kept", ckpt_full_o, 1'b1);

        // 4: correct resolve then mispredict restore
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, "t4r");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, "t4p");
        check("t4_ghr07", ghr_o, 8'h07);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, "t4c");
        check("t4_commit01", ghr_commit_o, 8'h01);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, "t4m");
        check("t4_ghr02", ghr_o, 8'h02);
        check("t4_empty", ckpt_empty_o, 1'b1);
        check("t4_commit02", ghr_commit_o, 8'h02);

        // 5: mispredict with coincident push, resolve on empty
        cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, "t5p");
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, "t5p");
        cyc(0, 0, 0, 0, 1, 1, 1, 1, 1, "t5m");
        check("t5_ghr05", ghr_o, 8'h05);
        check("t5_ovf0", ovf_o, 1'b0);
        check("t5_empty", ckpt_empty_o, 1'b1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, "t5e");
        check("t5_commit_hold", ghr_commit_o, 8'h05);

        // 6: stall freezes speculation, resolve still pops
        cyc(0, 0, 1, 32'h3FC, 1, 1, 0, 0, 0, "t6a");
        for (int i = 0; i < 4; i++)
            cyc(0, 1, i[0], 32'h1230 + 32'(i * 4), !i[0], 1, i == 2, 0, 0, "t6s");
        check("t6_ghr_frozen", ghr_o, 8'h0B);
        check("t6_commit", ghr_commit_o, 8'h0A);

        // Randomized phase against the model
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
                $urandom_range(0, 1), $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 1),
                $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 7) == 0,
                "rnd");
        end

        idle("end");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
